rsa_keygen_ctrl: RTL and testbench
==================================

// Module: rsa_keygen_ctrl
// PURPOSE
//  Sequencer for the private-key datapath. Latches p, q and e and derives n = p*q and totient = (p-1)*(q-1).
//  Range-checks the operands, then drives the datapath's enable/reset/operand pins and captures d.
//  Enforces a search timeout and recycles the datapath so back-to-back key requests work.
//  Sits between the host key-request interface and the private-key datapath.
// PARAMETERS
//  INPUTSIZE       24        width of e, n, totient, d; p/q are INPUTSIZE/2 bits (even values only)
//  TIMEOUT_CYCLES  67108864  max cycles in RUN before abort (counter is 32 bits wide)
// PORTS
//  clk          in   1          single clock, all logic on posedge
//  rst          in   1          synchronous, active-high reset
//  start        in   1          request; accepted only in IDLE
//  p, q         in   INPUTSIZE/2  primes, sampled on the accepted start cycle
//  e            in   INPUTSIZE  public exponent, sampled with p/q
//  busy         out  1          high from the cycle after accept until done/err
//  done         out  1          1-cycle pulse: n_out/e_out/d_out valid
//  err          out  1          1-cycle pulse: request aborted
//  err_code     out  3          0 none,1 BAD_PRIME,2 BAD_E,3 NOT_COPRIME,4 TIMEOUT,5 STALE; held until next accept
//  n_out,e_out,d_out out INPUTSIZE  key material, held until the next accept
//  pk_en        out  1          datapath enable
//  pk_rst       out  1          datapath reset
//  pk_e, pk_totient out INPUTSIZE  datapath operands; registered, stable while pk_en=1
//  pk_d         in   INPUTSIZE  datapath result
//  pk_complete  in   1          datapath level flag; must fall within 2 cycles of pk_rst
// BEHAVIOUR
//  Reset: all outputs 0, except pk_rst = 1 while rst = 1. State returns to IDLE; the timeout counter clears.
//  Reset mid-operation aborts without a done/err pulse.
//  FSM: IDLE -> LATCH -> VALIDATE -> [GCD] -> RUN -> RELEASE -> SETTLE(2 cycles) -> DONE -> IDLE;
//       any check failure -> ERR -> IDLE.
//  Timing from accepted start at cycle T:
//   - LATCH at T+1: register n and totient with full-width multiplies.
//   - VALIDATE at T+2.
//   - RUN from T+3 (no GCD) with pk_en = 1.
//  VALIDATE checks:
//   - p<2 or q<2 -> BAD_PRIME.
//   - e<2 or e>=totient -> BAD_E.
//  RUN: timeout counter increments each cycle.
//   - First cycle with pk_complete = 1 (cycle C): capture pk_d into d_out and go to RELEASE.
//   - Counter reaches TIMEOUT_CYCLES -> TIMEOUT; pk_en drops and the datapath is frozen.
//   - After TIMEOUT only rst recovers the datapath.
//  RELEASE at C+1: pk_en = 0, pk_rst = 1 for exactly one cycle.
//  SETTLE at C+2..C+3: pk_complete still 1 at the end of C+3 -> STALE.
//  DONE at C+4: done = 1, busy = 0.
//  ERR state: err = 1, busy = 0, pk_en = 0.
//  start while busy is ignored (no queueing). start in the DONE/ERR cycle is ignored; accept from the next IDLE cycle.
//  pk_complete is ignored outside RUN/SETTLE.
// CONFIGURATION
//  RSA_GCD_CHECK_EN defined:
//   - VALIDATE -> GCD state, which runs gcd(e, totient) iteratively.
//   - gcd != 1 -> NOT_COPRIME; gcd == 1 -> RUN.
//   - Adds a data-dependent latency, bounded by INPUTSIZE*2 cycles.
//  RSA_GCD_CHECK_EN undefined:
//   - No GCD state and no gcd_unit instance; VALIDATE -> RUN directly.
//   - A non-coprime e ends in TIMEOUT; err_code 3 is never produced.
// STRUCTURE
//  Shared package rsa_pkg:
//   - State enum.
//   - Error-code localparams ERR_NONE..ERR_STALE.
//   - Default INPUTSIZE constant.
//  Sub-module gcd_unit:
//   - Interface: start/busy/done with a registered result; subtractive or binary Euclid.
//   - Instantiated only under RSA_GCD_CHECK_EN.
// TESTING
//  p=5,q=11,e=3 -> n_out=55, internal totient 40, d_out=27, done 1 pulse, err_code=0.
//  After that, p=7,q=13,e=5 -> d_out=29, n_out=91; pk_rst pulsed exactly once between the runs.
//  p=1,q=11,e=3 -> err at T+3, err_code=1, pk_en never asserted.
//  p=5,q=11,e=40 -> err_code=2.
//  p=5,q=11,e=4:
//   - with RSA_GCD_CHECK_EN -> err_code=3;
//   - without, and TIMEOUT_CYCLES=200 -> err_code=4 exactly 200 cycles into RUN.
//  Model holds pk_complete high after pk_rst -> err_code=5.
//  start pulsed in the middle of RUN -> ignored, first result unchanged.
//  rst in the middle of RUN -> all outputs 0, IDLE, next request completes normally.

Source files
------------

// File: rtl/rsa_pkg.sv
// Shared types and constants for the RSA key-generation sequencer.
// The GCD state only exists when RSA_GCD_CHECK_EN is defined.
package rsa_pkg;

  localparam int DEFAULT_INPUTSIZE = 24;

  localparam logic [2:0] ERR_NONE        = 3'd0;
  localparam logic [2:0] ERR_BAD_PRIME   = 3'd1;
  localparam logic [2:0] ERR_BAD_E       = 3'd2;
  localparam logic [2:0] ERR_NOT_COPRIME = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT     = 3'd4;
  localparam logic [2:0] ERR_STALE       = 3'd5;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LATCH,
    S_VALIDATE,
`ifdef RSA_GCD_CHECK_EN
    S_GCD,
`endif
    S_RUN,
    S_RELEASE,
    S_SETTLE,
    S_DONE,
    S_ERR
  } state_t;

endpackage

// File: rtl/gcd_unit.sv
// Iterative binary GCD (Stein). Each cycle removes at least one bit from one
// of the operands, so a result takes at most about 2*W cycles.
module gcd_unit
  import rsa_pkg::*;
#(
  parameter int W = DEFAULT_INPUTSIZE
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result
);

  localparam int KW = $clog2(W) + 1;

  logic [W-1:0]  x, y;
  logic [KW-1:0] k;
  logic          running;

  always_ff @(posedge clk) begin
    if (rst) begin
      x       <= '0;
      y       <= '0;
      k       <= '0;
      running <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
    end else begin
      done <= 1'b0;
      if (!running) begin
        if (start) begin
          x       <= a;
          y       <= b;
          k       <= '0;
          running <= 1'b1;
        end
      end else if (x == '0) begin
        result  <= y << k;
        done    <= 1'b1;
        running <= 1'b0;
      end else if (y == '0) begin
        result  <= x << k;
        done    <= 1'b1;
        running <= 1'b0;
      end else begin
        // Odd-odd step subtracts and halves at once; the difference is always even.
        case ({x[0], y[0]})
          2'b00: begin
            x <= x >> 1;
            y <= y >> 1;
            k <= k + 1'b1;
          end
          2'b01:   x <= x >> 1;
          2'b10:   y <= y >> 1;
          default: begin
            if (x >= y) x <= (x - y) >> 1;
            else        y <= (y - x) >> 1;
          end
        endcase
      end
    end
  end

  assign busy = running;

endmodule

// File: rtl/rsa_keygen_ctrl.sv
// Sequencer for the private-key datapath: latches p/q/e, derives n and totient,
// range-checks, runs the datapath with a timeout and recycles it. Optional
// coprimality check enabled by RSA_GCD_CHECK_EN.
module rsa_keygen_ctrl
  import rsa_pkg::*;
#(
  parameter int          INPUTSIZE      = DEFAULT_INPUTSIZE,
  parameter int unsigned TIMEOUT_CYCLES = 67108864
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [INPUTSIZE/2-1:0] p,
  input  logic [INPUTSIZE/2-1:0] q,
  input  logic [INPUTSIZE-1:0]   e,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [2:0]             err_code,
  output logic [INPUTSIZE-1:0]   n_out,
  output logic [INPUTSIZE-1:0]   e_out,
  output logic [INPUTSIZE-1:0]   d_out,
  output logic                   pk_en,
  output logic                   pk_rst,
  output logic [INPUTSIZE-1:0]   pk_e,
  output logic [INPUTSIZE-1:0]   pk_totient,
  input  logic [INPUTSIZE-1:0]   pk_d,
  input  logic                   pk_complete
);

  localparam int                   HALF     = INPUTSIZE / 2;
  localparam logic [INPUTSIZE-1:0] ONE      = INPUTSIZE'(1);
  localparam logic [INPUTSIZE-1:0] TWO      = INPUTSIZE'(2);
  localparam logic [HALF-1:0]      TWO_H    = HALF'(2);
  localparam logic [31:0]          TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_t               state, state_nx;
  logic [HALF-1:0]      p_r, q_r;
  logic [INPUTSIZE-1:0] e_r, n_r, tot_r;
  logic [INPUTSIZE-1:0] p_ext, q_ext;
  logic [31:0]          tmo_cnt;
  logic                 settle_cnt;
  logic                 capture;
  logic                 err_load;
  logic [2:0]           err_code_nx;
  logic                 bad_prime, bad_e;

  assign p_ext     = INPUTSIZE'(p_r);
  assign q_ext     = INPUTSIZE'(q_r);
  assign bad_prime = (p_r < TWO_H) || (q_r < TWO_H);
  assign bad_e     = (e_r < TWO) || (e_r >= tot_r);

`ifdef RSA_GCD_CHECK_EN
  logic                 gcd_start, gcd_busy, gcd_done;
  logic [INPUTSIZE-1:0] gcd_result;

  gcd_unit #(.W(INPUTSIZE)) u_gcd (
    .clk    (clk),
    .rst    (rst),
    .start  (gcd_start),
    .a      (e_r),
    .b      (tot_r),
    .busy   (gcd_busy),
    .done   (gcd_done),
    .result (gcd_result)
  );
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      p_r        <= '0;
      q_r        <= '0;
      e_r        <= '0;
      n_r        <= '0;
      tot_r      <= '0;
      tmo_cnt    <= '0;
      settle_cnt <= 1'b0;
      err_code   <= ERR_NONE;
      n_out      <= '0;
      e_out      <= '0;
      d_out      <= '0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && start) begin
        p_r      <= p;
        q_r      <= q;
        e_r      <= e;
        err_code <= ERR_NONE;
      end
      if (state == S_LATCH) begin
        n_r   <= p_ext * q_ext;
        tot_r <= (p_ext - ONE) * (q_ext - ONE);
      end
      tmo_cnt    <= (state == S_RUN) ? tmo_cnt + 32'd1 : '0;
      settle_cnt <= (state == S_SETTLE) ? ~settle_cnt : 1'b0;
      if (capture) begin
        d_out <= pk_d;
        n_out <= n_r;
        e_out <= e_r;
      end
      if (err_load) err_code <= err_code_nx;
    end
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first so no latch is inferred.
    state_nx    = state;
    capture     = 1'b0;
    err_load    = 1'b0;
    err_code_nx = ERR_NONE;
`ifdef RSA_GCD_CHECK_EN
    gcd_start   = 1'b0;
`endif
    case (state)
      S_IDLE:     if (start) state_nx = S_LATCH;
      S_LATCH:    state_nx = S_VALIDATE;
      S_VALIDATE: begin
        if (bad_prime) begin
          state_nx    = S_ERR;
          err_load    = 1'b1;
          err_code_nx = ERR_BAD_PRIME;
        end else if (bad_e) begin
          state_nx    = S_ERR;
          err_load    = 1'b1;
          err_code_nx = ERR_BAD_E;
        end else begin
`ifdef RSA_GCD_CHECK_EN
          gcd_start = 1'b1;
          state_nx  = S_GCD;
`else
          state_nx  = S_RUN;
`endif
        end
      end
`ifdef RSA_GCD_CHECK_EN
      S_GCD: begin
        if (gcd_done && !gcd_busy) begin
          if (gcd_result == ONE) begin
            state_nx = S_RUN;
          end else begin
            state_nx    = S_ERR;
            err_load    = 1'b1;
            err_code_nx = ERR_NOT_COPRIME;
          end
        end
      end
`endif
      S_RUN: begin
        // A result arriving on the last budget cycle still wins over the timeout.
        if (pk_complete) begin
          capture  = 1'b1;
          state_nx = S_RELEASE;
        end else if (tmo_cnt == TMO_LAST) begin
          state_nx    = S_ERR;
          err_load    = 1'b1;
          err_code_nx = ERR_TIMEOUT;
        end
      end
      S_RELEASE:  state_nx = S_SETTLE;
      S_SETTLE: begin
        if (settle_cnt) begin
          if (pk_complete) begin
            state_nx    = S_ERR;
            err_load    = 1'b1;
            err_code_nx = ERR_STALE;
          end else begin
            state_nx = S_DONE;
          end
        end
      end
      S_DONE:     state_nx = S_IDLE;
      S_ERR:      state_nx = S_IDLE;
      default:    state_nx = S_IDLE;
    endcase
  end

  assign busy       = (state != S_IDLE) && (state != S_DONE) && (state != S_ERR);
  assign done       = (state == S_DONE);
  assign err        = (state == S_ERR);
  assign pk_en      = (state == S_RUN);
  assign pk_rst     = rst || (state == S_RELEASE);
  assign pk_e       = e_r;
  assign pk_totient = tot_r;

endmodule

// File: tb/tb_rsa_keygen_ctrl.sv
// Scoreboard bench for rsa_keygen_ctrl: directed requests push expected
// responses; a negedge monitor pops and compares on every done/err pulse.
`timescale 1ns/1ps
module tb_rsa_keygen_ctrl;
  import rsa_pkg::*;

  localparam int W   = 24;
  localparam int H   = W / 2;
  localparam int TMO = 200;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [H-1:0] p, q;
  logic [W-1:0] e;
  logic         busy, done, err;
  logic [2:0]   err_code;
  logic [W-1:0] n_out, e_out, d_out;
  logic         pk_en, pk_rst;
  logic [W-1:0] pk_e, pk_totient, pk_d;
  logic         pk_complete;

  always #5 clk = ~clk;

  rsa_keygen_ctrl #(.INPUTSIZE(W), .TIMEOUT_CYCLES(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .p           (p),
    .q           (q),
    .e           (e),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .err_code    (err_code),
    .n_out       (n_out),
    .e_out       (e_out),
    .d_out       (d_out),
    .pk_en       (pk_en),
    .pk_rst      (pk_rst),
    .pk_e        (pk_e),
    .pk_totient  (pk_totient),
    .pk_d        (pk_d),
    .pk_complete (pk_complete)
  );

  typedef struct {
    logic         is_err;
    logic [2:0]   code;
    logic [W-1:0] n, e, d;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   tests = 0, fails = 0;
  int   cyc = 0, t_acc = 0;
  int   n_resp = 0, resp_cyc = 0;
  int   pk_rst_cnt = 0, pk_en_cnt = 0, pk_en_first = -1;
  int   lat = 5;
  int   dp_cnt = 0;
  logic stale_mode = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference datapath: brute-force modular inverse, found after `lat` enabled cycles.
  function automatic int modinv(input int ev, input int tv);
    for (int d = 1; d < tv; d++)
      if ((ev * d) % tv == 1) return d;
    return -1;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (rst) begin
      pk_complete <= 1'b0;
      pk_d        <= '0;
      dp_cnt      <= 0;
    end else if (pk_rst && !stale_mode) begin
      pk_complete <= 1'b0;
      dp_cnt      <= 0;
    end else if (pk_en && !pk_complete) begin
      dp_cnt <= dp_cnt + 1;
      if (dp_cnt + 1 == lat && modinv(int'(pk_e), int'(pk_totient)) >= 0) begin
        pk_d        <= W'(modinv(int'(pk_e), int'(pk_totient)));
        pk_complete <= 1'b1;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (pk_rst) pk_rst_cnt++;
        if (pk_en) begin
          pk_en_cnt++;
          if (pk_en_first < 0) pk_en_first = cyc;
        end
        if (done || err) begin
          n_resp++;
          resp_cyc = cyc;
          if (sb.size() == 0) begin
            check("unexpected_response", {done, err}, 0);
          end else begin
            cur = sb.pop_front();
            check("resp_is_err", err, cur.is_err);
            check("resp_done", done, !cur.is_err);
            check("busy_low_at_resp", busy, 0);
            check("err_code", err_code, cur.code);
            if (!cur.is_err) begin
              check("n_out", n_out, cur.n);
              check("e_out", e_out, cur.e);
              check("d_out", d_out, cur.d);
            end
          end
        end
      end
    end
  end

  task automatic push_ok(input int nv, input int ev, input int dv);
    sb.push_back('{is_err: 1'b0, code: ERR_NONE, n: W'(nv), e: W'(ev), d: W'(dv)});
  endtask

  task automatic push_err(input logic [2:0] c);
    sb.push_back('{is_err: 1'b1, code: c, n: '0, e: '0, d: '0});
  endtask

  task automatic issue(input int pv, input int qv, input int ev);
    @(negedge clk);
    p = H'(pv); q = H'(qv); e = W'(ev); start = 1'b1;
    @(posedge clk);
    #1 t_acc = cyc;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_accept", busy, 1);
  endtask

  task automatic wait_resp(input string name, input int budget);
    int n0 = n_resp;
    int i  = 0;
    while (n_resp == n0 && i < budget) begin
      @(posedge clk);
      i++;
    end
    check({name, "_resp_seen"}, n_resp != n0, 1);
  endtask

  task automatic do_reset();
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    check("pk_rst_during_rst", pk_rst, 1);
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic check_idle_zero(input string name);
    check({name, "_busy"}, busy, 0);
    check({name, "_done_err"}, {done, err}, 0);
    check({name, "_err_code"}, err_code, 0);
    check({name, "_keys"}, {n_out, e_out, d_out}, 0);
    check({name, "_pk_ctrl"}, {pk_en, pk_rst}, 0);
    check({name, "_pk_ops"}, {pk_e, pk_totient}, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; p = '0; q = '0; e = '0;
    repeat (2) @(negedge clk);
    check("reset_pk_rst", pk_rst, 1);
    check("reset_busy", busy, 0);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    check_idle_zero("after_reset");

    // Back-to-back keys; the datapath must be recycled exactly once in between.
    pk_rst_cnt = 0;
    push_ok(55, 3, 27);
    issue(5, 11, 3);
    wait_resp("key1", 300);
    check("totient_5_11", pk_totient, 40);
    check("pk_rst_between_runs", pk_rst_cnt, 1);
    push_ok(91, 5, 29);
    issue(7, 13, 5);
    wait_resp("key2", 300);

    pk_en_cnt = 0;
    push_err(ERR_BAD_PRIME);
    issue(1, 11, 3);
    wait_resp("bad_prime", 50);
    check("bad_prime_err_latency", resp_cyc - t_acc, 2);
    check("bad_prime_no_pk_en", pk_en_cnt, 0);

    push_err(ERR_BAD_E);
    issue(5, 11, 40);
    wait_resp("bad_e", 50);

`ifdef RSA_GCD_CHECK_EN
    push_err(ERR_NOT_COPRIME);
    issue(5, 11, 4);
    wait_resp("not_coprime", 300);
`else
    pk_en_first = -1;
    push_err(ERR_TIMEOUT);
    issue(5, 11, 4);
    wait_resp("timeout", 400);
    check("timeout_run_cycles", resp_cyc - pk_en_first, TMO);
`endif
    do_reset();

    stale_mode = 1'b1;
    push_err(ERR_STALE);
    issue(5, 11, 3);
    wait_resp("stale", 300);
    stale_mode = 1'b0;
    do_reset();

    // A start pulse in the middle of a run must be ignored.
    lat = 20;
    push_ok(55, 3, 27);
    issue(5, 11, 3);
    repeat (5) @(negedge clk);
    p = H'(7); q = H'(13); e = W'(5); start = 1'b1;
    @(negedge clk) start = 1'b0;
    check("midrun_start_busy", busy, 1);
    check("midrun_start_pk_e", pk_e, 3);
    wait_resp("midrun_start", 300);
    repeat (3) @(negedge clk);
    check("midrun_start_no_extra", n_resp, 7);

    // Reset in the middle of RUN aborts silently; the next request completes.
    lat = 50;
    issue(7, 13, 5);
    for (int i = 0; i < 100 && !pk_en; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("rst_midrun_in_run", pk_en, 1);
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    check("rst_midrun_pk_rst", pk_rst, 1);
    rst = 1'b0;
    @(negedge clk);
    check_idle_zero("rst_midrun");
    lat = 5;
    push_ok(91, 5, 29);
    issue(7, 13, 5);
    wait_resp("after_rst", 300);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
